// File: rtl/io_uart_pkg.sv
// Shared constants for the IO-mapped UART: register offsets, STATUS bit
// positions and the state encoding used by both the TX and RX FSMs.
package io_uart_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int STAT_TX_FULL       = 0;
  localparam int STAT_TX_EMPTY      = 1;
  localparam int STAT_RX_EMPTY      = 2;
  localparam int STAT_RX_FULL       = 3;
  localparam int STAT_RX_OVERRUN    = 4;
  localparam int STAT_TX_BUSY       = 5;
  localparam int STAT_RX_FRAME_ERR  = 6;
  localparam int STAT_RX_PARITY_ERR = 7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter.
// A push while full is accepted only when a pop happens at the same edge.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rdata   = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; empty/full come from the reset pointers, so contents never matter.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/io_uart_responder.sv
// Memory-mapped UART: TXDATA/RXDATA/STATUS in a 16-byte window, TX and RX FIFOs.
// Define UART_PARITY_EN to add an even parity bit to every TX and RX frame.
module io_uart_responder
  import io_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  output logic [31:0] io_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);
`ifdef UART_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int              CW            = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      ST_AFTER_DATA = PARITY_EN ? ST_PARITY : ST_STOP;

  logic       w_hit;
  logic [3:0] w_off;
  logic       w_tx_wr;
  logic       w_st_wr;
  logic       w_rx_rd;
  logic       w_unused_bits;

  assign w_hit         = (io_address[31:4] == BASE_ADDR[31:4]);
  assign w_off         = {io_address[3:2], 2'b00};
  assign w_tx_wr       = io_write_en & w_hit & (w_off == OFF_TXDATA);
  assign w_st_wr       = io_write_en & w_hit & (w_off == OFF_STATUS);
  assign w_rx_rd       = io_read_en  & w_hit & (w_off == OFF_RXDATA);
  assign w_unused_bits = ^{io_address[1:0], io_write_value[31:8]};

  logic [7:0] w_tx_head;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_tx_pop;

  io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_tx_wr & ~w_tx_full),
    .i_wdata (io_write_value[7:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  logic [2:0]    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_data;
  logic          r_tx;
  logic          w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
  assign uart_tx      = r_tx;

  // An idle transmitter defers its first pop while a TXDATA write is in flight,
  // so a write burst fills the FIFO before the first frame leaves.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_tx_pop = 1'b0;
    case (r_tx_state)
      ST_IDLE: w_tx_pop = ~w_tx_empty & ~w_tx_wr;
      ST_STOP: w_tx_pop = w_tx_bit_end & ~w_tx_empty;
      default: w_tx_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_cnt <= (r_tx_state == ST_IDLE || w_tx_bit_end) ? '0 : r_tx_cnt + 1'b1;
      case (r_tx_state)
        ST_IDLE: if (w_tx_pop) begin
          r_tx_state <= ST_START;
          r_tx_data  <= w_tx_head;
          r_tx       <= 1'b0;
        end
        ST_START: if (w_tx_bit_end) begin
          r_tx_state <= ST_DATA;
          r_tx_idx   <= '0;
          r_tx       <= r_tx_data[0];
        end
        ST_DATA: if (w_tx_bit_end) begin
          if (r_tx_idx == 3'd7) begin
            r_tx_state <= ST_AFTER_DATA;
            r_tx       <= PARITY_EN ? even_parity(r_tx_data) : 1'b1;
          end else begin
            r_tx_idx <= r_tx_idx + 1'b1;
            r_tx     <= r_tx_data[r_tx_idx + 3'd1];
          end
        end
        ST_PARITY: if (w_tx_bit_end) begin
          r_tx_state <= ST_STOP;
          r_tx       <= 1'b1;
        end
        ST_STOP: if (w_tx_bit_end) begin
          if (w_tx_pop) begin
            r_tx_state <= ST_START;
            r_tx_data  <= w_tx_head;
            r_tx       <= 1'b0;
          end else begin
            r_tx_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx_state <= ST_IDLE;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_prev;
  logic [2:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_data;
  logic          r_rx_par_bad;
  logic          w_rx;
  logic          w_rx_mid;
  logic          w_rx_stop;
  logic          w_rx_valid;
  logic          w_frame_set;
  logic          w_parity_set;
  logic          w_ovr_set;
  logic [7:0]    w_rx_head;
  logic          w_rx_full;
  logic          w_rx_empty;

  // START waits half a bit to recheck the line; later bits are sampled a full bit apart.
  assign w_rx         = r_sync2;
  assign w_rx_mid     = (r_rx_cnt == ((r_rx_state == ST_START) ? HALF_LAST : BIT_LAST));
  assign w_rx_stop    = (r_rx_state == ST_STOP) & w_rx_mid;
  assign w_frame_set  = w_rx_stop & ~w_rx;
  assign w_parity_set = w_rx_stop & w_rx & r_rx_par_bad;
  assign w_rx_valid   = w_rx_stop & w_rx & ~r_rx_par_bad;
  assign w_ovr_set    = w_rx_valid & w_rx_full & ~w_rx_rd;

  io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_valid),
    .i_wdata (r_rx_data),
    .i_pop   (w_rx_rd),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= ST_IDLE;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_data    <= '0;
      r_rx_par_bad <= 1'b0;
    end else begin
      r_sync1   <= uart_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= w_rx;
      r_rx_cnt  <= (r_rx_state == ST_IDLE || w_rx_mid) ? '0 : r_rx_cnt + 1'b1;
      case (r_rx_state)
        ST_IDLE: if (r_rx_prev & ~w_rx) begin
          r_rx_state   <= ST_START;
          r_rx_par_bad <= 1'b0;
        end
        ST_START: if (w_rx_mid) begin
          r_rx_state <= w_rx ? ST_IDLE : ST_DATA;
          r_rx_idx   <= '0;
        end
        ST_DATA: if (w_rx_mid) begin
          r_rx_data <= {w_rx, r_rx_data[7:1]};
          r_rx_idx  <= r_rx_idx + 1'b1;
          if (r_rx_idx == 3'd7) r_rx_state <= ST_AFTER_DATA;
        end
        ST_PARITY: if (w_rx_mid) begin
          r_rx_par_bad <= (even_parity(r_rx_data) != w_rx);
          r_rx_state   <= ST_STOP;
        end
        ST_STOP: if (w_rx_mid) r_rx_state <= ST_IDLE;
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  logic r_rx_overrun;
  logic r_rx_frame_err;
  logic r_rx_parity_err;

  // A set in the same cycle as a software clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_overrun    <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_parity_err <= 1'b0;
    end else begin
      r_rx_overrun    <= w_ovr_set |
                         (r_rx_overrun & ~(w_st_wr & io_write_value[STAT_RX_OVERRUN]));
      r_rx_frame_err  <= w_frame_set |
                         (r_rx_frame_err & ~(w_st_wr & io_write_value[STAT_RX_FRAME_ERR]));
      r_rx_parity_err <= w_parity_set |
                         (r_rx_parity_err & ~(w_st_wr & io_write_value[STAT_RX_PARITY_ERR]));
    end
  end

  logic [7:0] w_status;

  always_comb begin
    w_status                     = '0;
    w_status[STAT_TX_FULL]       = w_tx_full;
    w_status[STAT_TX_EMPTY]      = w_tx_empty;
    w_status[STAT_RX_EMPTY]      = w_rx_empty;
    w_status[STAT_RX_FULL]       = w_rx_full;
    w_status[STAT_RX_OVERRUN]    = r_rx_overrun;
    w_status[STAT_TX_BUSY]       = (r_tx_state != ST_IDLE);
    w_status[STAT_RX_FRAME_ERR]  = r_rx_frame_err;
    w_status[STAT_RX_PARITY_ERR] = PARITY_EN & r_rx_parity_err;
  end

  always_comb begin
    io_read_value = '0;
    if (w_hit) begin
      case (w_off)
        OFF_RXDATA: io_read_value = {23'b0, w_rx_empty, (w_rx_empty ? 8'h00 : w_rx_head)};
        OFF_STATUS: io_read_value = {24'b0, w_status};
        default:    io_read_value = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_responder.sv
// Directed bench for io_uart_responder with TX/RX byte scoreboards.
// Build with UART_PARITY_EN defined to exercise the parity frame format.
`timescale 1ns/1ps
module tb_io_uart_responder;

  localparam int          CPB  = 16;
  localparam logic [31:0] A_TX = 32'h0000_1000;
  localparam logic [31:0] A_RX = 32'h0000_1004;
  localparam logic [31:0] A_ST = 32'h0000_1008;
  localparam logic [31:0] A_RS = 32'h0000_100C;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_read_value;
  logic        uart_tx;
  logic        uart_rx;

  int         total = 0;
  int         bad = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         mon_en = 1'b0;
  int         tx_frames = 0;

  always #5 clk = ~clk;

  io_uart_responder #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_address     (io_address),
    .io_write_value (io_write_value),
    .io_write_en    (io_write_en),
    .io_read_en     (io_read_en),
    .io_read_value  (io_read_value),
    .uart_tx        (uart_tx),
    .uart_rx        (uart_rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    io_address = addr; io_write_value = data; io_write_en = 1'b1;
    tick(1);
    io_write_en = 1'b0; io_address = A_ST;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    io_address = addr; io_read_en = 1'b1;
    #1 data = io_read_value;
    tick(1);
    io_read_en = 1'b0; io_address = A_ST;
  endtask

  task automatic get_status(output logic [31:0] s);
    io_address = A_ST;
    #1 s = io_read_value;
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] v;
    logic [31:0] exp;
    exp = 32'h0000_0100;
    if (rx_q.size() != 0) exp = {24'h0, rx_q.pop_front()};
    bus_read(A_RX, v);
    check(tag, v, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i]; tick(CPB);
    end
`ifdef UART_PARITY_EN
    uart_rx = ^d; tick(CPB);
`endif
    uart_rx = stop_bit; tick(CPB);
    uart_rx = 1'b1;
  endtask

  // TX scoreboard side: decode frames on uart_tx at mid-bit and pop expected bytes.
  initial begin : tx_monitor
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_mon start bit", {31'b0, uart_tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = uart_tx;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        check("tx_mon parity bit", {31'b0, uart_tx}, {31'b0, ^got});
`endif
        repeat (CPB) @(negedge clk);
        check("tx_mon stop bit", {31'b0, uart_tx}, 32'h1);
        tx_frames++;
        total++;
        assert (tx_q.size() != 0) else begin
          bad++;
          $error("FAIL tx_mon spurious frame: observed=0x%02h expected=none", got);
        end
        if (tx_q.size() != 0) check("tx_mon byte", {24'h0, got}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] v;
    logic [31:0] s;
    logic        exp_bit;
    int          errs;
    int          f0;
    logic [7:0]  d;

    reset = 1'b1; io_address = A_ST; io_write_value = '0;
    io_write_en = 1'b0; io_read_en = 1'b0; uart_rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    mon_en = 1'b1;

    // reset state and address decode
    get_status(s);
    check("reset status", s, 32'h0000_0006);
    check("reset uart_tx", {31'b0, uart_tx}, 32'h1);
    bus_read(A_TX, v);                 check("read txdata", v, 32'h0);
    bus_read(A_RS, v);                 check("read reserved", v, 32'h0);
    bus_write(32'h0000_2000, 32'h41);
    bus_read(32'h0000_2008, v);        check("read outside window", v, 32'h0);
    bus_read(A_ST | 32'h3, v);         check("status alias, outside write ignored", v, 32'h6);
    bus_write(A_RX, 32'h99);
    bus_read(A_RX, v);                 check("rxdata write ignored", v, 32'h100);

    // single TX frame, bit-exact
    d = 8'h55;
    tx_q.push_back(d);
    bus_write(A_TX, 32'h0000_0155);
    get_status(s);
    check("tx55 before start", {30'b0, uart_tx, s[5]}, 32'h2);
    tick(1);
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)          exp_bit = 1'b0;
      else if (b <= 8)     exp_bit = d[b-1];
      else if (b == 9 && NBITS == 11) exp_bit = ^d;
      else                 exp_bit = 1'b1;
      errs = 0;
      for (int c = 0; c < CPB; c++) begin
        get_status(s);
        if (uart_tx !== exp_bit || s[5] !== 1'b1) errs++;
        tick(1);
      end
      check($sformatf("tx55 bit%0d cycles wrong", b), errs, 0);
    end
    get_status(s);
    check("tx55 after stop", {30'b0, uart_tx, s[5]}, 32'h2);

    // TX FIFO overflow: 9 back-to-back writes, the 9th dropped
    tick(2);
    f0 = tx_frames;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(8'h10 + 8'(i * 17));
      bus_write(A_TX, 32'h10 + 32'(i * 17));
    end
    get_status(s);
    check("txfull status", s, 32'h0000_0005);
    for (int t = 0; t < 4000; t++) begin
      get_status(s);
      if (tx_q.size() == 0 && s[5] == 1'b0) break;
      tick(1);
    end
    check("txfull queue drained", 32'(tx_q.size()), 32'h0);
    tick(2 * NBITS * CPB);
    check("txfull frame count", 32'(tx_frames - f0), 32'd8);
    get_status(s);
    check("txfull idle status", s, 32'h0000_0006);

    // RX single byte then empty read
    rx_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    tick(2);
    rx_read_check("rx a3");
    rx_read_check("rx empty after a3");

    // RX overrun: 9 frames, no reads
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rx_q.push_back(8'h30 + 8'(i * 29));
      send_frame(8'h30 + 8'(i * 29), 1'b1);
    end
    tick(2);
    get_status(s);
    check("overrun status", s, 32'h0000_001A);
    bus_write(A_ST, 32'h10);
    get_status(s);
    check("overrun cleared only", s, 32'h0000_000A);
    for (int i = 0; i < 8; i++) rx_read_check($sformatf("overrun drain %0d", i));
    rx_read_check("overrun drained empty");

    // framing error
    send_frame(8'h5A, 1'b0);
    tick(2);
    get_status(s);
    check("frame error status", s, 32'h0000_0046);
    rx_read_check("frame error fifo empty");
    bus_write(A_ST, 32'h40);
    get_status(s);
    check("frame error cleared", s, 32'h0000_0006);

    // 3-cycle glitch is not a start bit
    uart_rx = 1'b0; tick(3); uart_rx = 1'b1;
    tick(NBITS * CPB + CPB);
    get_status(s);
    check("glitch status", s, 32'h0000_0006);
    rx_read_check("glitch no byte");

`ifdef UART_PARITY_EN
    // wrong parity bit: byte discarded, sticky bit7 set
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = v[i]; tick(CPB);
    end
    uart_rx = ~(^v[7:0]); tick(CPB);
    uart_rx = 1'b1; tick(CPB + 2);
    get_status(s);
    check("parity error status", s, 32'h0000_0086);
    bus_write(A_ST, 32'h80);
    get_status(s);
    check("parity error cleared", s, 32'h0000_0006);
`endif

    // reset in the middle of data bit 4 of a TX frame
    mon_en = 1'b0;
    bus_write(A_TX, 32'h0F);
    tick(1 + 5 * CPB + 3);
    get_status(s);
    check("midframe before reset", {30'b0, uart_tx, s[5]}, 32'h1);
    reset = 1'b1;
    io_address = A_TX; io_write_value = 32'h77; io_write_en = 1'b1;
    tick(1);
    check("midframe uart_tx after reset", {31'b0, uart_tx}, 32'h1);
    io_write_en = 1'b0;
    reset = 1'b0;
    get_status(s);
    check("midframe status after reset", s, 32'h0000_0006);
    errs = 0;
    for (int c = 0; c < 2 * NBITS * CPB; c++) begin
      if (uart_tx !== 1'b1) errs++;
      tick(1);
    end
    check("write during reset ignored", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
